// File: rtl/regfile_wb_queue.sv
// ============================================================================
// Module   : regfile_wb_queue
// Purpose  : Two-source in-order write-back queue feeding the 32x32 register
//            file, with optional forwarding lookup (macro WB_FWD_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [AW-1:0]            a_reg,
    input  logic [DW-1:0]            a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [AW-1:0]            b_reg,
    input  logic [DW-1:0]            b_data,
    output logic                     wb_we,
    output logic [AW-1:0]            wb_reg,
    output logic [DW-1:0]            wb_data,
    input  logic [AW-1:0]            look1_reg,
    input  logic [AW-1:0]            look2_reg,
    output logic                     fwd1_hit,
    output logic [DW-1:0]            fwd1_data,
    output logic                     fwd2_hit,
    output logic [DW-1:0]            fwd2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     idle
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

    logic [AW-1:0] r_mem_reg  [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_wb_we;
    logic [AW-1:0] r_wb_reg;
    logic [DW-1:0] r_wb_data;

    logic          w_acc_a;
    logic          w_acc_b;
    logic          w_pop;
    logic [PW-1:0] w_b_slot;

    // Readiness uses pre-edge occupancy only; a slot freed by this cycle's pop
    // is not handed out until the next cycle.
    assign a_ready  = r_count < C_DEPTH;
    assign w_acc_a  = a_valid && a_ready && (a_reg != '0);
    assign b_ready  = (r_count + CW'(w_acc_a)) < C_DEPTH;
    assign w_acc_b  = b_valid && b_ready && (b_reg != '0);
    assign w_pop    = r_count != '0;
    assign w_b_slot = r_wr_ptr + PW'(w_acc_a);

    always_ff @(posedge clk) begin
        if (w_acc_a) begin
            r_mem_reg[r_wr_ptr]  <= a_reg;
            r_mem_data[r_wr_ptr] <= a_data;
        end
        if (w_acc_b) begin
            r_mem_reg[w_b_slot]  <= b_reg;
            r_mem_data[w_b_slot] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wb_we   <= 1'b0;
            r_wb_reg  <= '0;
            r_wb_data <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_acc_a) + PW'(w_acc_b);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_acc_a) + CW'(w_acc_b) - CW'(w_pop);
            r_wb_we  <= w_pop;
            if (w_pop) begin
                r_wb_reg  <= r_mem_reg[r_rd_ptr];
                r_wb_data <= r_mem_data[r_rd_ptr];
            end
        end
    end

    assign wb_we   = r_wb_we;
    assign wb_reg  = r_wb_reg;
    assign wb_data = r_wb_data;
    assign count   = r_count;
    assign idle    = (r_count == '0) && !r_wb_we;

`ifdef WB_FWD_EN
    for (genvar k = 0; k < 2; k++) begin : g_fwd
        logic [AW-1:0] w_key;
        logic          w_hit;
        logic [DW-1:0] w_data;

        assign w_key = (k == 0) ? look1_reg : look2_reg;

        // Scan oldest to newest so the newest matching entry overrides.
        always_comb begin
            logic [PW-1:0] v_idx;
            w_hit  = 1'b0;
            w_data = '0;
            v_idx  = '0;
            if (r_wb_we && (r_wb_reg == w_key)) begin
                w_hit  = 1'b1;
                w_data = r_wb_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                v_idx = r_rd_ptr + PW'(i);
                if ((CW'(i) < r_count) && (r_mem_reg[v_idx] == w_key)) begin
                    w_hit  = 1'b1;
                    w_data = r_mem_data[v_idx];
                end
            end
            if (w_key == '0) begin
                w_hit  = 1'b0;
                w_data = '0;
            end
        end

        if (k == 0) begin : g_port1
            assign fwd1_hit  = w_hit;
            assign fwd1_data = w_data;
        end else begin : g_port2
            assign fwd2_hit  = w_hit;
            assign fwd2_data = w_data;
        end
    end
`else
    logic w_unused_look;
    assign w_unused_look = ^{look1_reg, look2_reg};
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
// ============================================================================
// Module   : tb_regfile_wb_queue
// Purpose  : Directed self-checking bench for regfile_wb_queue (DEPTH 4 and 2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_reg, b_reg, wb_reg, look1_reg, look2_reg;
    logic [31:0] a_data, b_data, wb_data, fwd1_data, fwd2_data;
    logic        wb_we, fwd1_hit, fwd2_hit, idle;
    logic [2:0]  count;

    logic        d2_a_valid, d2_b_valid, d2_a_ready, d2_b_ready;
    logic [4:0]  d2_a_reg, d2_b_reg, d2_wb_reg;
    logic [31:0] d2_a_data, d2_b_data, d2_wb_data, d2_fwd1_data, d2_fwd2_data;
    logic        d2_wb_we, d2_fwd1_hit, d2_fwd2_hit, d2_idle;
    logic [1:0]  d2_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .look1_reg(look1_reg), .look2_reg(look2_reg),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count), .idle(idle)
    );

    regfile_wb_queue #(.DEPTH(2), .AW(5), .DW(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(d2_a_valid), .a_ready(d2_a_ready), .a_reg(d2_a_reg), .a_data(d2_a_data),
        .b_valid(d2_b_valid), .b_ready(d2_b_ready), .b_reg(d2_b_reg), .b_data(d2_b_data),
        .wb_we(d2_wb_we), .wb_reg(d2_wb_reg), .wb_data(d2_wb_data),
        .look1_reg(5'd0), .look2_reg(5'd0),
        .fwd1_hit(d2_fwd1_hit), .fwd1_data(d2_fwd1_data),
        .fwd2_hit(d2_fwd2_hit), .fwd2_data(d2_fwd2_data),
        .count(d2_count), .idle(d2_idle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] r, input logic [31:0] d);
        chk({tag, "_we"}, 64'(wb_we), 64'd1);
        chk({tag, "_reg"}, 64'(wb_reg), 64'(r));
        chk({tag, "_data"}, 64'(wb_data), 64'(d));
    endtask

    task automatic chk_wb2(input string tag, input logic [4:0] r, input logic [31:0] d);
        chk({tag, "_we"}, 64'(d2_wb_we), 64'd1);
        chk({tag, "_reg"}, 64'(d2_wb_reg), 64'(r));
        chk({tag, "_data"}, 64'(d2_wb_data), 64'(d));
    endtask

    // Advance one edge, then model the register file capturing the write port.
    task automatic step();
        @(posedge clk);
        #1;
        if (wb_we) rf[wb_reg] = wb_data;
    endtask

    initial begin
        a_valid = 0; b_valid = 0; a_reg = 0; b_reg = 0; a_data = 0; b_data = 0;
        look1_reg = 0; look2_reg = 0;
        d2_a_valid = 0; d2_b_valid = 0; d2_a_reg = 0; d2_b_reg = 0;
        d2_a_data = 0; d2_b_data = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;

        step(); step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_we", 64'(wb_we), 64'd0);
        chk("rst_reg", 64'(wb_reg), 64'd0);
        chk("rst_data", 64'(wb_data), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_fwd1", 64'(fwd1_hit), 64'd0);
        rst_n = 1;
        #1;
        chk("rel_a_ready", 64'(a_ready), 64'd1);
        chk("rel_b_ready", 64'(b_ready), 64'd1);

        // single write, latency
        a_valid = 1; a_reg = 5; a_data = 32'h11;
        step();
        a_valid = 0;
        chk("t1_count", 64'(count), 64'd1);
        chk("t1_we0", 64'(wb_we), 64'd0);
        step();
        chk_wb("t1_wb", 5, 32'h11);
        chk("t1_idle0", 64'(idle), 64'd0);
        step();
        chk("t1_we_off", 64'(wb_we), 64'd0);
        chk("t1_idle", 64'(idle), 64'd1);
        chk("t1_hold_reg", 64'(wb_reg), 64'd5);

        // same-cycle A then B to the same register
        a_valid = 1; a_reg = 3; a_data = 32'hAA;
        b_valid = 1; b_reg = 3; b_data = 32'hBB;
        #1;
        chk("t2_b_ready", 64'(b_ready), 64'd1);
        step();
        a_valid = 0; b_valid = 0;
        chk("t2_count", 64'(count), 64'd2);
        step();
        chk_wb("t2_wb_a", 3, 32'hAA);
        step();
        chk_wb("t2_wb_b", 3, 32'hBB);
        step();
        chk("t2_rf3", 64'(rf[3]), 64'hBB);

        // sustained stream: A every cycle, B for two cycles
        a_valid = 1; a_reg = 1; a_data = 32'h101;
        b_valid = 1; b_reg = 2; b_data = 32'h201;
        step();
        chk("t3_count2", 64'(count), 64'd2);
        chk("t3_we0", 64'(wb_we), 64'd0);
        a_reg = 3; a_data = 32'h103; b_reg = 4; b_data = 32'h204;
        #1;
        chk("t3_b_ready_c2", 64'(b_ready), 64'd1);
        step();
        chk("t3_count3", 64'(count), 64'd3);
        chk_wb("t3_wb1", 1, 32'h101);
        b_valid = 0; a_reg = 5; a_data = 32'h105;
        step();
        chk_wb("t3_wb2", 2, 32'h201);
        a_reg = 6; a_data = 32'h106;
        step();
        chk_wb("t3_wb3", 3, 32'h103);
        a_reg = 7; a_data = 32'h107;
        #1;
        chk("t3_b_ready_c3", 64'(b_ready), 64'd0);
        chk("t3_a_ready_c3", 64'(a_ready), 64'd1);
        step();
        chk_wb("t3_wb4", 4, 32'h204);
        a_valid = 0;
        step();
        chk_wb("t3_wb5", 5, 32'h105);
        chk("t3_count_dn", 64'(count), 64'd2);
        step();
        chk_wb("t3_wb6", 6, 32'h106);
        step();
        chk_wb("t3_wb7", 7, 32'h107);
        step();
        chk("t3_idle", 64'(idle), 64'd1);

        // register 0 is handshaken but dropped
        a_valid = 1; a_reg = 0; a_data = 32'hFF;
        #1;
        chk("t4_a_ready", 64'(a_ready), 64'd1);
        step();
        a_valid = 0;
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_we_a", 64'(wb_we), 64'd0);
        step();
        chk("t4_we_b", 64'(wb_we), 64'd0);
        chk("t4_idle", 64'(idle), 64'd1);

        // forwarding: reg 7 = 1 then reg 7 = 2
        look1_reg = 7; look2_reg = 0;
        a_valid = 1; a_reg = 7; a_data = 32'h1;
        b_valid = 1; b_reg = 7; b_data = 32'h2;
        #1;
        chk("t5_pre_hit", 64'(fwd1_hit), 64'd0);
        step();
        a_valid = 0; b_valid = 0;
`ifdef WB_FWD_EN
        chk("t5_q_hit", 64'(fwd1_hit), 64'd1);
        chk("t5_q_data", 64'(fwd1_data), 64'd2);
        step();
        chk("t5_w1_hit", 64'(fwd1_hit), 64'd1);
        chk("t5_w1_data", 64'(fwd1_data), 64'd2);
        step();
        chk("t5_w2_hit", 64'(fwd1_hit), 64'd1);
        chk("t5_w2_data", 64'(fwd1_data), 64'd2);
`else
        chk("t5_q_hit", 64'(fwd1_hit), 64'd0);
        chk("t5_q_data", 64'(fwd1_data), 64'd0);
        step();
        chk("t5_w1_hit", 64'(fwd1_hit), 64'd0);
        step();
        chk("t5_w2_hit", 64'(fwd1_hit), 64'd0);
        chk("t5_w2_data", 64'(fwd1_data), 64'd0);
`endif
        chk_wb("t5_wb2", 7, 32'h2);
        chk("t5_look0", 64'(fwd2_hit), 64'd0);
        step();
        chk("t5_gone_hit", 64'(fwd1_hit), 64'd0);
        look1_reg = 0;

        // DEPTH=2 instance: fill, blocked while full despite a pop
        d2_a_valid = 1; d2_a_reg = 9;  d2_a_data = 32'h90;
        d2_b_valid = 1; d2_b_reg = 10; d2_b_data = 32'hA0;
        step();
        chk("d2_full_count", 64'(d2_count), 64'd2);
        d2_a_reg = 11; d2_a_data = 32'hB0; d2_b_reg = 12; d2_b_data = 32'hC0;
        #1;
        chk("d2_a_ready_full", 64'(d2_a_ready), 64'd0);
        chk("d2_b_ready_full", 64'(d2_b_ready), 64'd0);
        step();
        chk_wb2("d2_wb9", 9, 32'h90);
        chk("d2_count1", 64'(d2_count), 64'd1);
        chk("d2_b_ready_1", 64'(d2_b_ready), 64'd0);
        chk("d2_a_ready_1", 64'(d2_a_ready), 64'd1);
        step();
        chk_wb2("d2_wb10", 10, 32'hA0);
        d2_a_valid = 0;
        #1;
        chk("d2_b_ready_2", 64'(d2_b_ready), 64'd1);
        step();
        chk_wb2("d2_wb11", 11, 32'hB0);
        d2_b_valid = 0;
        step();
        chk_wb2("d2_wb12", 12, 32'hC0);
        step();
        chk("d2_idle", 64'(d2_idle), 64'd1);

        // reset asserted with three writes pending
        a_valid = 1; a_reg = 8;  a_data = 32'h81;
        b_valid = 1; b_reg = 9;  b_data = 32'h91;
        step();
        a_reg = 10; a_data = 32'hA1; b_reg = 11; b_data = 32'hB1;
        step();
        a_valid = 0; b_valid = 0;
        chk("t6_count3", 64'(count), 64'd3);
        rst_n = 0;
        #1;
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_we", 64'(wb_we), 64'd0);
        chk("t6_rst_reg", 64'(wb_reg), 64'd0);
        chk("t6_rst_data", 64'(wb_data), 64'd0);
        step();
        rst_n = 1;
        step();
        chk("t6_post_we_a", 64'(wb_we), 64'd0);
        step();
        chk("t6_post_we_b", 64'(wb_we), 64'd0);
        chk("t6_post_idle", 64'(idle), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
